// File: rtl/program_counter_br.sv
// Fetch-stage program counter: parametrised increment, stall, relative branch and absolute jump.
// Optional PC_MISALIGN_TRAP_EN: misaligned jump targets are refused and flagged on a sticky misalign output.
//
// state  | meaning
// BOOT   | first cycle after reset, fetch address not yet valid
// RUN    | sequential fetch, pc_valid=1
// BUBBLE | one cycle after an accepted redirect, pc_valid=0
module program_counter_br #(
   parameter int ADDR_W = 32,
   parameter int OFF_W  = 16,
   parameter int INC    = 4,
   parameter logic [0:ADDR_W-1] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              jump,
   input  logic [0:ADDR_W-1] jump_target,
   input  logic              branch_taken,
   input  logic [0:OFF_W-1]  branch_offset,
   output logic [0:ADDR_W-1] pc,
   output logic [0:ADDR_W-1] next_pc,
   output logic              pc_valid,
`ifdef PC_MISALIGN_TRAP_EN
   output logic              misalign,
`endif
   output logic              redirect
);

   typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

   localparam logic [0:ADDR_W-1] INC_V = ADDR_W'(INC);
   localparam logic [0:ADDR_W-1] LOW2  = ADDR_W'(3);

   state_t            state;
   logic [0:ADDR_W-1] off_ext;
   logic [0:ADDR_W-1] pc_seq;
   logic [0:ADDR_W-1] pc_branch;
   logic [0:ADDR_W-1] jump_aligned;
   logic              jump_trap;

   // Bit 0 is the MSB, so the sign bit of the offset is branch_offset[0].
   assign off_ext      = {{(ADDR_W-OFF_W){branch_offset[0]}}, branch_offset};
   assign pc_seq       = pc + INC_V;
   assign pc_branch    = pc + (off_ext << 2);
   assign jump_aligned = jump_target & ~LOW2;

`ifdef PC_MISALIGN_TRAP_EN
   assign jump_trap = jump & (|(jump_target & LOW2));
`else
   assign jump_trap = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         next_pc  <= RESET_PC >> 2;
         pc_valid <= 1'b0;
         redirect <= 1'b0;
         state    <= BOOT;
      end else if (stall) begin
         // Redirect requests arriving during a stall are dropped.
         redirect <= 1'b0;
      end else begin
         next_pc <= pc >> 2;
         if (jump && !jump_trap) begin
            pc       <= jump_aligned;
            redirect <= 1'b1;
            pc_valid <= 1'b0;
            state    <= BUBBLE;
         end else if (branch_taken && !jump) begin
            pc       <= pc_branch;
            redirect <= 1'b1;
            pc_valid <= 1'b0;
            state    <= BUBBLE;
         end else begin
            pc       <= pc_seq;
            redirect <= 1'b0;
            pc_valid <= 1'b1;
            state    <= RUN;
         end
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         misalign <= 1'b0;
      else if (!stall && jump_trap)
         misalign <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_program_counter_br.sv
// Directed self-checking bench for program_counter_br (default parameters).
module tb_program_counter_br;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        jump;
   logic [0:31] jump_target;
   logic        branch_taken;
   logic [0:15] branch_offset;
   logic [0:31] pc;
   logic [0:31] next_pc;
   logic        pc_valid;
   logic        redirect;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int tests  = 0;
   int failed = 0;

   program_counter_br dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .pc            (pc),
      .next_pc       (next_pc),
      .pc_valid      (pc_valid),
`ifdef PC_MISALIGN_TRAP_EN
      .misalign      (misalign),
`endif
      .redirect      (redirect)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_npc,
                            input logic e_valid, input logic e_redir);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".next_pc"}, next_pc, e_npc);
      chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
      chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, e_redir});
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; jump = 1'b0; jump_target = '0;
      branch_taken = 1'b0; branch_offset = '0;
      #1;
      chk_state("reset_async", 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      chk_state("reset_hold", 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;

      // free run after release
      step(); chk_state("run1", 32'h4, 32'h0, 1'b1, 1'b0);
      step(); chk_state("run2", 32'h8, 32'h1, 1'b1, 1'b0);
      step(); chk_state("run3", 32'hC, 32'h2, 1'b1, 1'b0);
      step(); chk_state("run4", 32'h10, 32'h3, 1'b1, 1'b0);

      // stall with a jump request that must be dropped
      stall = 1'b1; jump = 1'b1; jump_target = 32'h500;
      for (int i = 0; i < 3; i++) begin
         step(); chk_state("stall", 32'h10, 32'h3, 1'b1, 1'b0);
      end
      stall = 1'b0; jump = 1'b0;
      step(); chk_state("stall_release", 32'h14, 32'h4, 1'b1, 1'b0);

      // jump to 0x100, then branch -4 instructions from inside the bubble
      jump = 1'b1; jump_target = 32'h100;
      step(); chk_state("jump_100", 32'h100, 32'h5, 1'b0, 1'b1);
      jump = 1'b0; branch_taken = 1'b1; branch_offset = 16'hFFFC;
      step(); chk_state("branch_neg", 32'hF0, 32'h40, 1'b0, 1'b1);
      branch_taken = 1'b0; branch_offset = '0;
      step(); chk_state("after_branch", 32'hF4, 32'h3C, 1'b1, 1'b0);

      // jump/branch collision with a misaligned target
      jump = 1'b1; jump_target = 32'h2003; branch_taken = 1'b1; branch_offset = 16'h0010;
      step();
`ifdef PC_MISALIGN_TRAP_EN
      chk_state("collide", 32'hF8, 32'h3D, 1'b1, 1'b0);
      chk("collide.misalign", {31'd0, misalign}, 32'd1);
`else
      chk_state("collide", 32'h2000, 32'h3D, 1'b0, 1'b1);
`endif
      jump = 1'b0; branch_taken = 1'b0; branch_offset = '0;
      step();
`ifdef PC_MISALIGN_TRAP_EN
      chk_state("collide_next", 32'hFC, 32'h3E, 1'b1, 1'b0);
      chk("misalign_sticky", {31'd0, misalign}, 32'd1);
`else
      chk_state("collide_next", 32'h2004, 32'h800, 1'b1, 1'b0);
`endif

      // wrap at the top of the address space
      jump = 1'b1; jump_target = 32'hFFFF_FFFC;
      step(); chk("wrap_jump.pc", pc, 32'hFFFF_FFFC);
      jump = 1'b0;
      step(); chk_state("wrap0", 32'h0, 32'h3FFF_FFFF, 1'b1, 1'b0);
      step(); chk_state("wrap1", 32'h4, 32'h0, 1'b1, 1'b0);

      // asynchronous reset in the middle of a bubble
      jump = 1'b1; jump_target = 32'h40;
      step(); chk_state("bubble_pre_rst", 32'h40, 32'h1, 1'b0, 1'b1);
      jump = 1'b0;
      #2 rst = 1'b0;
      #1 chk_state("rst_mid_bubble", 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
`endif
      step(); step();
      rst = 1'b1;
      chk_state("boot", 32'h0, 32'h0, 1'b0, 1'b0);
      step(); chk_state("boot_run", 32'h4, 32'h0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/program_counter_br.md
Name: program_counter_br

Overview:
- Parametrised successor to the fixed 32-bit incrementing program counter for the Troy WideWord processor fetch stage.
- Holds the byte-address PC, advances by a parametrised increment, and accepts stall, relative-branch and absolute-jump redirects.
- Emits a registered word address to instruction memory, plus a valid flag that bubbles for one cycle after every redirect.
- Vectors use the [0:N-1] ordering; bit 0 is the MSB.

Parameters:
- ADDR_W, 32: PC and target width in bits.
- OFF_W, 16: signed branch-offset width in bits, counted in instructions.
- INC, 4: byte increment per sequential fetch; a power of two, ≥4.
- RESET_PC, 0: byte address loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- stall  in  1  hold all state this cycle.
- jump  in  1  absolute redirect request.
- jump_target  in  ADDR_W  absolute byte address.
- branch_taken  in  1  relative redirect request.
- branch_offset  in  OFF_W  signed instruction offset from the current pc.
- pc  out  ADDR_W  current byte-address PC.
- next_pc  out  ADDR_W  word address, pc>>2, registered one cycle behind pc.
- pc_valid  out  1  next_pc is a valid sequential fetch address.
- redirect  out  1  one-cycle pulse when a jump or branch is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, next_pc=RESET_PC>>2, pc_valid=0, redirect=0, FSM=BOOT.
  - Reset wins mid-redirect and mid-stall.
  - Release is sampled on the next clk rising edge.
- FSM states:
  - BOOT: one cycle after reset; pc_valid stays 0, then go to RUN.
  - RUN: pc_valid=1.
  - BUBBLE: entered for exactly one cycle after an accepted redirect; pc_valid=0, then back to RUN.
- Per-edge priority, when not in reset: stall > jump > branch_taken > sequential increment.
- stall=1:
  - pc, next_pc, pc_valid and FSM all hold.
  - redirect=0.
  - jump and branch requests are ignored (dropped, not queued).
  - Stall during BUBBLE extends the bubble.
- jump=1:
  - pc <= jump_target with its low 2 bits cleared.
  - redirect=1 for one cycle; FSM -> BUBBLE.
- branch_taken=1 (no jump):
  - pc <= pc + (sign_extend(branch_offset) << 2).
  - redirect=1 for one cycle; FSM -> BUBBLE.
- Otherwise: pc <= pc + INC.
- next_pc <= pc >> 2 every non-stalled edge, giving one cycle of latency behind pc.
- Arithmetic:
  - All additions are modulo 2^ADDR_W.
  - pc=2^ADDR_W-INC wraps to 0 with no flag.
  - A negative offset below 0 wraps the same way.
- Simultaneous jump and branch_taken: the jump is taken and the branch is discarded.
- Redirects are accepted in BOOT and BUBBLE; each starts a fresh one-cycle bubble.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - An accepted jump with jump_target[ADDR_W-2:ADDR_W-1] != 0 is not taken.
  - pc keeps incrementing by INC; misalign=1 and sticky until reset.
  - redirect=0 for that request.
- Undefined:
  - No misalign port.
  - The low 2 bits are silently cleared and the jump is taken.

Test Plan:
- Reset then free-run: rst=0 for 2 cycles, then release.
  - pc goes 0,4,8,12.
  - next_pc goes 0,0,1,2 (one behind).
  - pc_valid is 0 for one cycle, then 1.
- Stall: at pc=0x10, hold stall=1 for 3 cycles.
  - pc=0x10 and next_pc=0x3 are held.
  - A jump asserted during the stall is ignored.
  - After release, pc becomes 0x14.
- Branch: at pc=0x100, branch_taken=1 with branch_offset=-4 (16-bit 0xFFFC).
  - Next pc=0xF0; redirect pulses for 1 cycle.
  - pc_valid=0 for 1 cycle.
  - Then pc=0xF4 and pc_valid=1.
- Jump/branch collision: jump=1 to 0x2003 and branch_taken=1 in the same cycle.
  - pc=0x2000.
  - Without the macro, the branch is discarded.
  - With PC_MISALIGN_TRAP_EN, no jump is taken, pc increments and misalign=1 (sticky).
- Wrap: force pc=0xFFFFFFFC (jump to it), then let it run.
  - The next cycles give pc=0, then 4.
  - No error flag is raised.
- Asynchronous reset mid-BUBBLE: drop rst between clock edges.
  - pc=RESET_PC, pc_valid=0 and redirect=0 immediately, without waiting for a clk edge.
